// File: rtl/fifo_button_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fifo_button_ctrl_if                                    |
// | Description : Button / FIFO-flag / strobe bundle for fifo_button_ctrl|
// |               master = controller side, slave = board/FIFO side.     |
// |               `level` exists only when FIFO_CTRL_LEVEL_EN is defined.|
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface fifo_button_ctrl_if #(
    parameter int LVL_W = 3
);
    logic button_wrd;
    logic button_red;
    logic full;
    logic empty;
    logic wr_en;
    logic rd_en;
    logic write;
    logic read;
    logic wr_rej;
    logic rd_rej;
`ifdef FIFO_CTRL_LEVEL_EN
    logic [LVL_W:0] level;
`endif

    modport master (
        input  button_wrd, button_red, full, empty,
`ifdef FIFO_CTRL_LEVEL_EN
        output level,
`endif
        output wr_en, rd_en, write, read, wr_rej, rd_rej
    );

    modport slave (
        output button_wrd, button_red, full, empty,
`ifdef FIFO_CTRL_LEVEL_EN
        input  level,
`endif
        input  wr_en, rd_en, write, read, wr_rej, rd_rej
    );
endinterface
`default_nettype wire

// File: rtl/fifo_button_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fifo_button_ctrl                                       |
// | Description : Push-button front end and access arbiter for an 8-bit  |
// |               FIFO. Synchronises and debounces the write/read        |
// |               buttons, turns each press into one wr_en/rd_en strobe, |
// |               and rejects requests against full/empty.               |
// |               Optional macro FIFO_CTRL_LEVEL_EN adds an occupancy    |
// |               counter on the interface `level` signal.               |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module fifo_button_ctrl #(
    parameter int DB_CYCLES = 3,
    parameter int CNT_W     = 4,
    parameter int LVL_W     = 3
) (
    input  logic                 clk,
    input  logic                 clr,
    fifo_button_ctrl_if.master   bus
);

    // Debounce counter value at which the next differing sample flips the level
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // Round-robin pointer: side that wins the next contested cycle
    localparam logic [0:0] c_RR_WRITE = 1'b0;
    localparam logic [0:0] c_RR_READ  = 1'b1;

    // Index 0 = write button, index 1 = read button
    logic [1:0] w_raw;
    logic [1:0] w_db;
    logic [1:0] w_press;

    assign w_raw = {bus.button_red, bus.button_wrd};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_btn
            logic             r_sync1;
            logic             r_sync2;
            logic             r_lvl;
            logic             r_lvl_d;
            logic [CNT_W-1:0] r_cnt;

            // Two-flop synchroniser, then a level debouncer that needs
            // DB_CYCLES consecutive differing samples before it flips
            always_ff @(posedge clk) begin
                if (clr) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_lvl   <= 1'b0;
                    r_lvl_d <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_raw[g];
                    r_sync2 <= r_sync1;
                    r_lvl_d <= r_lvl;
                    if (r_sync2 == r_lvl) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_lvl <= ~r_lvl;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_db[g]    = r_lvl;
            // Press = debounced level going 0->1; releases are ignored
            assign w_press[g] = r_lvl & ~r_lvl_d;
        end
    endgenerate

    logic       r_wr_pend;
    logic       r_rd_pend;
    logic [0:0] r_rr;
    logic       r_wr_en;
    logic       r_rd_en;
    logic       r_wr_rej;
    logic       r_rd_rej;

    logic w_wr_req;
    logic w_rd_req;
    logic w_grant_wr;
    logic w_grant_rd;
    logic w_contest;

    // A fresh press is served in the same cycle it appears, so the strobe
    // lands one edge after the debounced level rises
    assign w_wr_req   = r_wr_pend | w_press[0];
    assign w_rd_req   = r_rd_pend | w_press[1];
    assign w_contest  = w_wr_req & w_rd_req;
    assign w_grant_wr = w_wr_req & (~w_rd_req | (r_rr == c_RR_WRITE));
    assign w_grant_rd = w_rd_req & ~w_grant_wr;

    // Arbiter: one grant per cycle, registered strobes/rejects, pointer
    // advances only when both sides actually competed
    always_ff @(posedge clk) begin
        if (clr) begin
            r_wr_pend <= 1'b0;
            r_rd_pend <= 1'b0;
            r_rr      <= c_RR_WRITE;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_wr_rej  <= 1'b0;
            r_rd_rej  <= 1'b0;
        end else begin
            r_wr_pend <= w_wr_req & ~w_grant_wr;
            r_rd_pend <= w_rd_req & ~w_grant_rd;
            r_wr_en   <= w_grant_wr & ~bus.full;
            r_wr_rej  <= w_grant_wr &  bus.full;
            r_rd_en   <= w_grant_rd & ~bus.empty;
            r_rd_rej  <= w_grant_rd &  bus.empty;
            if (w_contest) begin
                r_rr <= w_grant_wr ? c_RR_READ : c_RR_WRITE;
            end
        end
    end

    assign bus.wr_en  = r_wr_en;
    assign bus.rd_en  = r_rd_en;
    assign bus.wr_rej = r_wr_rej;
    assign bus.rd_rej = r_rd_rej;
    assign bus.write  = w_db[0];
    assign bus.read   = w_db[1];

`ifdef FIFO_CTRL_LEVEL_EN
    localparam logic [LVL_W:0] c_LVL_MAX = {1'b1, {LVL_W{1'b0}}};

    logic [LVL_W:0] r_level;

    // Occupancy tracks issued strobes, saturating at depth and at zero
    always_ff @(posedge clk) begin
        if (clr) begin
            r_level <= '0;
        end else if (r_wr_en && (r_level != c_LVL_MAX)) begin
            r_level <= r_level + 1'b1;
        end else if (r_rd_en && (r_level != '0)) begin
            r_level <= r_level - 1'b1;
        end
    end

    assign bus.level = r_level;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_button_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fifo_button_ctrl                                    |
// | Description : Directed bench for fifo_button_ctrl (DB_CYCLES=3,      |
// |               20 ns clock). Level checks run when FIFO_CTRL_LEVEL_EN |
// |               is defined.                                            |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_fifo_button_ctrl;

    logic clk;
    logic clr;

    fifo_button_ctrl_if #(.LVL_W(3)) bus ();

    fifo_button_ctrl #(
        .DB_CYCLES (3),
        .CNT_W     (4),
        .LVL_W     (3)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Edge counter and pulse monitor (sampled on the falling edge)
    int cyc = 0;
    int wr_cnt, rd_cnt, wrej_cnt, rrej_cnt, both_cnt, read_hi_cnt;
    int wr_cyc, rd_cyc;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.wr_en)  begin wr_cnt++; wr_cyc = cyc; end
        if (bus.rd_en)  begin rd_cnt++; rd_cyc = cyc; end
        if (bus.wr_rej) wrej_cnt++;
        if (bus.rd_rej) rrej_cnt++;
        if (bus.wr_en && bus.rd_en) both_cnt++;
        if (bus.read)   read_hi_cnt++;
    end

    task automatic clear_counts();
        wr_cnt = 0; rd_cnt = 0; wrej_cnt = 0; rrej_cnt = 0;
        both_cnt = 0; read_hi_cnt = 0; wr_cyc = -1; rd_cyc = -1;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #5 clr = 1'b0;
    endtask

`ifdef FIFO_CTRL_LEVEL_EN
    task automatic press_wr();
        @(posedge clk); #5 bus.button_wrd = 1'b1;
        repeat (10) @(posedge clk); #5 bus.button_wrd = 1'b0;
        repeat (10) @(posedge clk); #5;
    endtask

    task automatic press_rd();
        @(posedge clk); #5 bus.button_red = 1'b1;
        repeat (10) @(posedge clk); #5 bus.button_red = 1'b0;
        repeat (10) @(posedge clk); #5;
    endtask
`endif

    int c0;

    initial begin
        bus.button_wrd = 1'b0;
        bus.button_red = 1'b0;
        bus.full       = 1'b0;
        bus.empty      = 1'b0;
        clear_counts();

        // Reset state
        do_reset();
        @(posedge clk); #5;
        check("rst_wr_en",  int'(bus.wr_en),  0);
        check("rst_rd_en",  int'(bus.rd_en),  0);
        check("rst_write",  int'(bus.write),  0);
        check("rst_read",   int'(bus.read),   0);
        check("rst_rejects", int'({bus.wr_rej, bus.rd_rej}), 0);

        // 1: bouncing write press; first steady sample at edge c0+2
        clear_counts();
        @(posedge clk); #5; c0 = cyc;
        #4  bus.button_wrd = 1'b1;
        #8  bus.button_wrd = 1'b0;
        #8  bus.button_wrd = 1'b1;
        #200;
        check("t1_wr_count", wr_cnt, 1);
        check("t1_wr_edge",  wr_cyc, c0 + 7);
        check("t1_write_lvl", int'(bus.write), 1);
        check("t1_no_rd", rd_cnt + wrej_cnt + rrej_cnt, 0);
        bus.button_wrd = 1'b0;
        repeat (10) @(posedge clk); #5;
        check("t1_release_lvl", int'(bus.write), 0);
        check("t1_release_nostrobe", wr_cnt, 1);

        // 2: 30 ns glitch on the read button
        clear_counts();
        @(posedge clk); #3 bus.button_red = 1'b1;
        #30 bus.button_red = 1'b0;
        repeat (12) @(posedge clk); #5;
        check("t2_read_lvl", read_hi_cnt, 0);
        check("t2_no_rd_en", rd_cnt, 0);
        check("t2_no_rd_rej", rrej_cnt, 0);

        // 3: simultaneous presses, round-robin order alternates
        do_reset();
        clear_counts();
        @(posedge clk); #5;
        bus.button_wrd = 1'b1; bus.button_red = 1'b1;
        repeat (12) @(posedge clk); #5;
        check("t3a_wr_count", wr_cnt, 1);
        check("t3a_rd_count", rd_cnt, 1);
        check("t3a_rd_after_wr", rd_cyc - wr_cyc, 1);
        bus.button_wrd = 1'b0; bus.button_red = 1'b0;
        repeat (10) @(posedge clk); #5;
        clear_counts();
        bus.button_wrd = 1'b1; bus.button_red = 1'b1;
        repeat (12) @(posedge clk); #5;
        check("t3b_wr_count", wr_cnt, 1);
        check("t3b_rd_count", rd_cnt, 1);
        check("t3b_wr_after_rd", wr_cyc - rd_cyc, 1);
        check("t3_never_both", both_cnt, 0);
        bus.button_wrd = 1'b0; bus.button_red = 1'b0;
        repeat (10) @(posedge clk); #5;

        // 4: rejects against full / empty
        clear_counts();
        bus.full = 1'b1;
        bus.button_wrd = 1'b1;
        repeat (12) @(posedge clk); #5;
        check("t4_wr_rej", wrej_cnt, 1);
        check("t4_wr_en_blocked", wr_cnt, 0);
        bus.button_wrd = 1'b0; bus.full = 1'b0;
        repeat (10) @(posedge clk); #5;
        bus.empty = 1'b1;
        bus.button_red = 1'b1;
        repeat (12) @(posedge clk); #5;
        check("t4_rd_rej", rrej_cnt, 1);
        check("t4_rd_en_blocked", rd_cnt, 0);
        bus.button_red = 1'b0; bus.empty = 1'b0;
        repeat (10) @(posedge clk); #5;

        // 5: reset mid-debounce with the button held
        clear_counts();
        @(posedge clk); #5; c0 = cyc;
        bus.button_wrd = 1'b1;
        repeat (4) @(posedge clk); #5;
        clr = 1'b1;
        @(posedge clk); #5;
        check("t5_no_strobe_before", wr_cnt, 0);
        check("t5_outs_zero", int'({bus.wr_en, bus.rd_en, bus.write, bus.read,
                                    bus.wr_rej, bus.rd_rej}), 0);
        clr = 1'b0;
        repeat (12) @(posedge clk); #5;
        check("t5_wr_count", wr_cnt, 1);
        check("t5_wr_edge", wr_cyc, c0 + 11);
        bus.button_wrd = 1'b0;
        repeat (10) @(posedge clk); #5;

`ifdef FIFO_CTRL_LEVEL_EN
        // 6: occupancy count up to 5 and back to 0
        do_reset();
        @(posedge clk); #5;
        check("t6_level_rst", int'(bus.level), 0);
        for (int i = 1; i <= 5; i++) begin
            press_wr();
            check($sformatf("t6_level_up%0d", i), int'(bus.level), i);
        end
        for (int i = 4; i >= 0; i--) begin
            press_rd();
            check($sformatf("t6_level_dn%0d", i), int'(bus.level), i);
        end
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
